ibm_pro: RTL

IBM_PRO -- requirements
Module: ibm_pro

---
 rtl/ibm_pro.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ibm_pro.sv
// ibm_pro: input buffer manager packet filter.
// Accepts beat-tagged packets (tag 01 head, 11 body, 10 tail), forwards packets
// whose head carries an accepted type, truncates over-long packets, discards
// the rest, and emits per-packet valid/metadata toward the data cache.
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   in_ibm_data/_wr                    input beat and strobe
//   in_ibm_valid/_wr                   per-packet valid flag (read on tail)
//   in_ibm_tsn_md/_wr                  TSN metadata and capture strobe
//   in_ibm_ID, in_ibm_ID_count         buffer ID and free-ID count
//   cfg_type_single/_lo/_hi            accepted packet types
//   out_ibm_data/_wr                   forwarded beat and strobe
//   out_ibm_valid/_wr                  packet valid report
//   out_ibm_md/_wr                     packet metadata
//   out_ibm_bufm_ID                    delayed ID count
//   stat_pkt_cnt/drop_cnt/trunc_cnt    saturating statistics
module ibm_pro #(
  parameter int DW        = 134,
  parameter int TYPE_LSB  = 80,
  parameter int MDW       = 24,
  parameter int IDW       = 8,
  parameter int CNTW      = 5,
  parameter int MAX_BEATS = 128,
  parameter int ID_DLY    = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   in_ibm_data,
  input  logic            in_ibm_data_wr,
  input  logic            in_ibm_valid,
  input  logic            in_ibm_valid_wr,
  input  logic [MDW-1:0]  in_ibm_tsn_md,
  input  logic            in_ibm_tsn_md_wr,
  input  logic [IDW-1:0]  in_ibm_ID,
  input  logic [CNTW-1:0] in_ibm_ID_count,
  input  logic [7:0]      cfg_type_single,
  input  logic [7:0]      cfg_type_lo,
  input  logic [7:0]      cfg_type_hi,
  output logic [DW-1:0]   out_ibm_data,
  output logic            out_ibm_data_wr,
  output logic            out_ibm_valid,
  output logic            out_ibm_valid_wr,
  output logic [MDW-1:0]  out_ibm_md,
  output logic            out_ibm_md_wr,
  output logic [CNTW-1:0] out_ibm_bufm_ID,
  output logic [31:0]     stat_pkt_cnt,
  output logic [31:0]     stat_drop_cnt,
  output logic [15:0]     stat_trunc_cnt
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, TRANS, DISC} state_t;

  state_t            state;
  logic [CW-1:0]     beat_cnt;
  // Only the upper metadata bits are ever emitted; the low bits carry the ID.
  logic [MDW-1:IDW]  tsn_md_q;
  logic              md_pend;
  logic [CNTW-1:0]   id_pipe [ID_DLY];

  logic [1:0]        tag;
  logic              is_head;
  logic              is_tail;
  logic [7:0]        pkt_type;
  logic              type_ok;
  logic [DW-1:0]     forced_tail;
  logic              unused_ok;

  always_comb begin
    tag         = in_ibm_data[DW-1:DW-2];
    is_head     = (tag == 2'b01);
    is_tail     = (tag == 2'b10);
    pkt_type    = in_ibm_data[TYPE_LSB +: 8];
    type_ok     = (pkt_type == cfg_type_single) ||
                  ((pkt_type >= cfg_type_lo) && (pkt_type <= cfg_type_hi));
    forced_tail = {2'b10, in_ibm_data[DW-3:0]};
  end

  assign unused_ok = ^{in_ibm_valid_wr, in_ibm_tsn_md[IDW-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      beat_cnt         <= '0;
      out_ibm_data     <= '0;
      out_ibm_data_wr  <= 1'b0;
      out_ibm_valid    <= 1'b0;
      out_ibm_valid_wr <= 1'b0;
      stat_pkt_cnt     <= '0;
      stat_drop_cnt    <= '0;
      stat_trunc_cnt   <= '0;
    end else begin
      out_ibm_data     <= '0;
      out_ibm_data_wr  <= 1'b0;
      out_ibm_valid    <= 1'b0;
      out_ibm_valid_wr <= 1'b0;
      if (in_ibm_data_wr) begin
        case (state)
          IDLE: begin
            if (is_head) begin
              if (type_ok) begin
                out_ibm_data    <= in_ibm_data;
                out_ibm_data_wr <= 1'b1;
                beat_cnt        <= CW'(1);
                state           <= TRANS;
              end else begin
                if (stat_drop_cnt != '1) stat_drop_cnt <= stat_drop_cnt + 1'b1;
                state <= DISC;
              end
            end
          end
          TRANS: begin
            out_ibm_data_wr <= 1'b1;
            if (is_head) begin
              // New head before tail: close the open packet, drop the new one.
              out_ibm_data     <= forced_tail;
              out_ibm_valid_wr <= 1'b1;
              if (stat_drop_cnt != '1) stat_drop_cnt <= stat_drop_cnt + 1'b1;
              state <= DISC;
            end else if (is_tail) begin
              out_ibm_data     <= in_ibm_data;
              out_ibm_valid    <= in_ibm_valid;
              out_ibm_valid_wr <= 1'b1;
              if (stat_pkt_cnt != '1) stat_pkt_cnt <= stat_pkt_cnt + 1'b1;
              state <= IDLE;
            end else if (beat_cnt == CW'(MAX_BEATS - 1)) begin
              out_ibm_data     <= forced_tail;
              out_ibm_valid_wr <= 1'b1;
              if (stat_trunc_cnt != '1) stat_trunc_cnt <= stat_trunc_cnt + 1'b1;
              state <= DISC;
            end else begin
              out_ibm_data <= in_ibm_data;
              beat_cnt     <= beat_cnt + 1'b1;
            end
          end
          DISC: begin
            if (is_tail) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Metadata follows a valid tail report by two cycles; tsn_md_q is read
  // before any capture on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tsn_md_q      <= '0;
      md_pend       <= 1'b0;
      out_ibm_md    <= '0;
      out_ibm_md_wr <= 1'b0;
    end else begin
      if (in_ibm_tsn_md_wr) tsn_md_q <= in_ibm_tsn_md[MDW-1:IDW];
      md_pend       <= out_ibm_valid_wr & out_ibm_valid;
      out_ibm_md_wr <= md_pend;
      if (md_pend) out_ibm_md <= {tsn_md_q, in_ibm_ID};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ID_DLY; i++) id_pipe[i] <= '0;
    end else begin
      id_pipe[0] <= in_ibm_ID_count;
      for (int unsigned i = 1; i < ID_DLY; i++) id_pipe[i] <= id_pipe[i-1];
    end
  end

  assign out_ibm_bufm_ID = id_pipe[ID_DLY-1];

endmodule
